sequential_divider: RTL and testbench

// Unsigned restoring divider, one quotient bit per clock (shift-and-subtract).

---
 rtl/sequential_divider.sv | 141 ++++++++++++++
 tb/tb_sequential_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// ----------------------------------------------------------------------------
// sequential_divider
//
// Unsigned restoring divider that produces one quotient bit per clock using
// shift-and-subtract. It uses a start/ready handshake with an IDLE/WORKING/DONE
// controller. The datapath holds three registers and a counter:
//   A : partial remainder, WIDTH+1 bits
//   Q : starts as the dividend and ends as the quotient, WIDTH bits
//   M : divisor, WIDTH bits
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        request to begin; only accepted in IDLE or DONE
//   dividend     captured when a start is accepted
//   divisor      captured when a start is accepted
//   ready        high in DONE; quotient/remainder are valid
//   busy         high while iterating (WORKING)
//   quotient     Q register
//   remainder    low WIDTH bits of the A register
//   div_by_zero  set when the captured divisor was zero
// ----------------------------------------------------------------------------
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WORKING,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             w_accept;

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_count;
    logic             r_divByZero;

    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_unused;

    // One restoring step. The combined {A,Q} is shifted left, and the divisor
    // is subtracted from the upper half. The sign bit of the difference decides
    // whether to keep the difference or restore the shifted value.
    always_comb begin
        w_shift = {r_a, r_q} << 1;
        w_trial = w_shift[2*WIDTH:WIDTH] - {1'b0, r_m};
    end

    // The low bit of the shifted word is always zero. It is replaced by the
    // new quotient bit, so this bit is never read.
    assign w_unused = w_shift[0];

    // Next-state logic. A start request is only honoured in IDLE or DONE. In
    // WORKING, the iteration with the counter at zero is still performed.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = WORKING;
                end
            end
            WORKING: begin
                if (r_count == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = WORKING;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register and datapath. Reset takes priority over a start request
    // in the same cycle, and it clears any division in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_count     <= '0;
            r_divByZero <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_a         <= '0;
                r_q         <= dividend;
                r_m         <= divisor;
                r_divByZero <= (divisor == '0);
                r_count     <= CW'(WIDTH - 1);
            end else if (r_state == WORKING) begin
                if (w_trial[WIDTH] == 1'b0) begin
                    r_a <= w_trial;
                    r_q <= {w_shift[WIDTH-1:1], 1'b1};
                end else begin
                    r_a <= w_shift[2*WIDTH:WIDTH];
                    r_q <= {w_shift[WIDTH-1:1], 1'b0};
                end
                if (r_count != '0) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Handshake outputs are decoded directly from the state register.
    assign ready       = (r_state == DONE);
    assign busy        = (r_state == WORKING);
    assign quotient    = r_q;
    assign remainder   = r_a[WIDTH-1:0];
    assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_sequential_divider.sv
// ----------------------------------------------------------------------------
// tb_sequential_divider
//
// Directed and random testbench for sequential_divider with WIDTH = 8.
// Each accepted request pushes its expected quotient, remainder and flag onto
// a scoreboard queue. The entry is popped and compared when ready rises.
// ----------------------------------------------------------------------------
module tb_sequential_divider;

    localparam int W       = 8;
    localparam int LATENCY = W + 1;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } expect_t;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    expect_t sb[$];
    int      nChecks;
    int      nErrors;

    sequential_divider #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compares one observed value against the value this bench expects.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a request at a falling edge and records the expected result.
    // The task returns at the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [W-1:0] dd, input logic [W-1:0] dv);
        expect_t e;
        e.dd  = dd;
        e.dv  = dv;
        e.dbz = (dv == '0);
        e.q   = (dv == '0) ? {W{1'b1}} : W'(dd / dv);
        e.r   = (dv == '0) ? dd : W'(dd % dv);
        @(negedge clock);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits for ready, with a cycle budget, and checks the latency and the
    // scoreboard entry. The accepting edge counts as cycle 1. For the first
    // holdCycles cycles, start is kept high and the operands keep changing.
    task automatic checkOutput(input string tag, input int holdCycles, input bit checkInvariant);
        int      cyc;
        expect_t e;
        logic [15:0] recon;
        cyc = 1;
        check({tag, ".busyFirst"}, 32'(busy), 32'd1);
        check({tag, ".readyFirst"}, 32'(ready), 32'd0);
        if (holdCycles >= 1) begin
            start    = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
        while (ready !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clock);
            cyc++;
            if (cyc <= holdCycles) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(cyc), 32'(LATENCY));
        if (sb.size() == 0) begin
            check({tag, ".scoreboardEmpty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".quotient"}, 32'(quotient), 32'(e.q));
            check({tag, ".remainder"}, 32'(remainder), 32'(e.r));
            check({tag, ".divByZero"}, 32'(div_by_zero), 32'(e.dbz));
            if (checkInvariant && e.dv != '0) begin
                recon = 16'(quotient) * 16'(e.dv) + 16'(remainder);
                check({tag, ".invariant"}, 32'(recon), 32'(e.dd));
                check({tag, ".remLess"}, 32'(remainder < e.dv), 32'd1);
            end
        end
    endtask

    // Directed sequence followed by a random sweep.
    initial begin
        nChecks  = 0;
        nErrors  = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (3) @(negedge clock);
        check("reset.ready", 32'(ready), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.quotient", 32'(quotient), 32'd0);
        check("reset.remainder", 32'(remainder), 32'd0);
        check("reset.divByZero", 32'(div_by_zero), 32'd0);
        reset = 1'b0;

        applyStimulus(8'd100, 8'd7);
        checkOutput("d100_7", 0, 1'b1);
        applyStimulus(8'd255, 8'd1);
        checkOutput("d255_1", 0, 1'b1);
        applyStimulus(8'd5, 8'd9);
        checkOutput("d5_9", 0, 1'b1);
        applyStimulus(8'd0, 8'd3);
        checkOutput("d0_3", 0, 1'b1);
        applyStimulus(8'd200, 8'd200);
        checkOutput("d200_200", 0, 1'b1);
        applyStimulus(8'd37, 8'd0);
        checkOutput("d37_0", 0, 1'b0);

        // Start stays high for the whole iteration window while the operands
        // change. The captured 100/7 must still be the result.
        applyStimulus(8'd100, 8'd7);
        checkOutput("holdStart", W, 1'b1);

        // Restart directly from DONE. Ready must drop on the next cycle.
        applyStimulus(8'd50, 8'd6);
        checkOutput("restartDone", 0, 1'b1);

        // Reset during the 4th WORKING cycle abandons the division.
        applyStimulus(8'd100, 8'd7);
        repeat (3) @(negedge clock);
        check("midReset.busyBefore", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midReset.ready", 32'(ready), 32'd0);
        check("midReset.busy", 32'(busy), 32'd0);
        check("midReset.quotient", 32'(quotient), 32'd0);
        check("midReset.remainder", 32'(remainder), 32'd0);
        check("midReset.divByZero", 32'(div_by_zero), 32'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        applyStimulus(8'd9, 8'd4);
        checkOutput("afterReset9_4", 0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            checkOutput("random", 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
